pipe_ctrl: RTL and testbench

Pipeline control unit for the five-stage Y86 core: it decides every cycle whether each pipeline register (F, F/D, ID/EX, EX/MEM, MEM/WB) loads, holds (stall) or inserts a nop bubble. It covers load-use hazards, jump mispredicts, the three-cycle `ret` window, multi-cycle memory freezes and halt, and keeps saturating stall and bubble counters. It sits beside the datapath, reads stage icodes and registers, and drives the stall/bubble pins of the stage registers.

---
 rtl/pipe_ctrl_pkg.sv | 35 +++
 rtl/sat_cnt.sv | 46 ++++
 rtl/pipe_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared constants for the Y86 pipeline control unit: instruction codes seen
// by the hazard logic, the "no register" id, the controller state encoding and
// a small helper that recognises instructions that read data memory.
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam int BYTE_W = 8;

  // Instruction codes (upper nibble of the Y86 opcode byte, zero-extended)
  localparam logic [BYTE_W-1:0] I_HALT   = 8'h0;
  localparam logic [BYTE_W-1:0] I_NOP    = 8'h1;
  localparam logic [BYTE_W-1:0] I_MRMOVL = 8'h5;
  localparam logic [BYTE_W-1:0] I_JXX    = 8'h7;
  localparam logic [BYTE_W-1:0] I_RET    = 8'h9;
  localparam logic [BYTE_W-1:0] I_POPL   = 8'hB;

  // Register id meaning "no register used"
  localparam logic [BYTE_W-1:0] RNONE = 8'hF;

  // Controller states
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_RET_WAIT = 2'd1,
    ST_HALTED   = 2'd2
  } state_t;

  // True for instructions whose result comes from data memory, i.e. whose
  // destination is only available after the memory stage.
  function automatic logic is_load_op(input logic [BYTE_W-1:0] icode);
    return (icode == I_MRMOVL) || (icode == I_POPL);
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// ---------------------------------------------------------------------------
// sat_cnt
// Saturating up-counter used for the pipeline performance counters. Counts
// one per cycle while inc is high and sticks at all-ones instead of wrapping.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-low reset, clears the count
//   inc    in   increment request for this cycle
//   count  out  current count value (CNT_W bits)
// ---------------------------------------------------------------------------
module sat_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             at_max;

  assign at_max = &count_reg;

  always_comb begin
    count_next = count_reg;
    if (inc && !at_max) begin
      count_next = count_reg + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// Pipeline control unit for the five-stage Y86 core. Each cycle it decides
// whether the F, F/D, ID/EX, EX/MEM and MEM/WB registers load, hold or take
// a nop bubble, covering load-use hazards, jump mispredicts, the ret window,
// memory freezes and halt. Control outputs are combinational; state and the
// performance counters are registered.
//
// Ports:
//   clk        in   core clock, rising edge
//   rst        in   asynchronous active-low reset
//   d_icode    in   icode in decode
//   d_srcA/B   in   decode source registers (RNONE = none)
//   e_icode    in   icode in execute
//   e_dstM     in   execute memory-destination register
//   e_cnd      in   jump condition evaluated in execute
//   m_busy     in   memory access not finished this cycle
//   w_icode    in   icode in writeback
//   f_stall, d_stall, e_stall, m_stall   out  hold the stage register
//   d_bubble, e_bubble, w_bubble         out  load a nop into the register
//   halted     out  core stopped
//   stall_cnt  out  cycles with fetch stalled (excluding HALTED), saturating
//   bubble_cnt out  cycles with a D or E bubble, saturating
// ---------------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] d_icode,
  input  logic [BYTE_W-1:0] d_srcA,
  input  logic [BYTE_W-1:0] d_srcB,
  input  logic [BYTE_W-1:0] e_icode,
  input  logic [BYTE_W-1:0] e_dstM,
  input  logic              e_cnd,
  input  logic              m_busy,
  input  logic [BYTE_W-1:0] w_icode,
  output logic              f_stall,
  output logic              d_stall,
  output logic              e_stall,
  output logic              m_stall,
  output logic              d_bubble,
  output logic              e_bubble,
  output logic              w_bubble,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  state_t     state_reg, state_next;
  logic [1:0] rcnt_reg, rcnt_next;

  logic mispredict;
  logic load_use;
  logic stall_inc;
  logic bubble_inc;

  // Jumps are predicted taken, so a not-taken jump in execute means the two
  // younger instructions in F/D and ID/EX are on the wrong path.
  assign mispredict = (e_icode == I_JXX) && !e_cnd;

  // RNONE on both sides must not count as a dependency.
  assign load_use = is_load_op(e_icode) && (e_dstM != RNONE) &&
                    ((e_dstM == d_srcA) || (e_dstM == d_srcB));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_RUN;
      rcnt_reg  <= 2'd0;
    end else begin
      state_reg <= state_next;
      rcnt_reg  <= rcnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rcnt_next  = rcnt_reg;
    f_stall    = 1'b0;
    d_stall    = 1'b0;
    e_stall    = 1'b0;
    m_stall    = 1'b0;
    d_bubble   = 1'b0;
    e_bubble   = 1'b0;
    w_bubble   = 1'b0;

    if (state_reg == ST_HALTED) begin
      // Whole pipe frozen; only reset leaves this state.
      f_stall  = 1'b1;
      d_stall  = 1'b1;
      e_stall  = 1'b1;
      m_stall  = 1'b1;
      w_bubble = 1'b1;
    end else if (m_busy) begin
      // Memory freeze: everything upstream holds, writeback sees a nop, and
      // the ret window does not advance (also defers a pending halt).
      f_stall  = 1'b1;
      d_stall  = 1'b1;
      e_stall  = 1'b1;
      m_stall  = 1'b1;
      w_bubble = 1'b1;
    end else begin
      if (mispredict) begin
        // The ret being squashed was on the wrong path, so drop its window.
        d_bubble   = 1'b1;
        e_bubble   = 1'b1;
        state_next = ST_RUN;
        rcnt_next  = 2'd0;
      end else if (load_use) begin
        // Hold the consumer in decode one cycle; state is left untouched.
        f_stall  = 1'b1;
        d_stall  = 1'b1;
        e_bubble = 1'b1;
      end else if (state_reg == ST_RET_WAIT) begin
        f_stall  = 1'b1;
        d_bubble = 1'b1;
        if (rcnt_reg == 2'd1) begin
          state_next = ST_RUN;
          rcnt_next  = 2'd0;
        end else begin
          rcnt_next = rcnt_reg - 2'd1;
        end
      end else if (d_icode == I_RET) begin
        // Return address is unknown until ret reaches writeback: detect
        // cycle plus two more bubble cycles.
        f_stall    = 1'b1;
        d_bubble   = 1'b1;
        state_next = ST_RET_WAIT;
        rcnt_next  = 2'd2;
      end

      // Halt in writeback overrides any next-state choice above.
      if (w_icode == I_HALT) begin
        state_next = ST_HALTED;
      end
    end
  end

  assign halted = (state_reg == ST_HALTED);

  assign stall_inc  = f_stall && (state_reg != ST_HALTED);
  assign bubble_inc = d_bubble || e_bubble;

  sat_cnt #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (stall_inc),
    .count(stall_cnt)
  );

  sat_cnt #(
    .CNT_W(CNT_W)
  ) u_bubble_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (bubble_inc),
    .count(bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl
// Directed bench for pipe_ctrl. A 32-bit instance carries the main checks; a
// 3-bit-counter instance on the same inputs exercises counter saturation.
// Control outputs are packed as {f_stall,d_stall,e_stall,m_stall,
// d_bubble,e_bubble,w_bubble,halted}.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

  localparam logic [7:0] C_IDLE   = 8'h00;
  localparam logic [7:0] C_LU     = 8'hC4;
  localparam logic [7:0] C_RET    = 8'h88;
  localparam logic [7:0] C_MISP   = 8'h0C;
  localparam logic [7:0] C_FREEZE = 8'hF2;
  localparam logic [7:0] C_HALT   = 8'hF3;

  localparam logic [7:0] HALT = 8'h0, NOP = 8'h1, MRMOVL = 8'h5;
  localparam logic [7:0] JXX = 8'h7, RET = 8'h9, POPL = 8'hB, RNONE = 8'hF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d_icode, d_srcA, d_srcB, e_icode, e_dstM, w_icode;
  logic       e_cnd, m_busy;

  logic        f_stall, d_stall, e_stall, m_stall;
  logic        d_bubble, e_bubble, w_bubble, halted;
  logic [31:0] stall_cnt, bubble_cnt;

  logic        s_f_stall, s_d_stall, s_e_stall, s_m_stall;
  logic        s_d_bubble, s_e_bubble, s_w_bubble, s_halted;
  logic [2:0]  s_stall_cnt, s_bubble_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .d_icode(d_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .e_icode(e_icode), .e_dstM(e_dstM), .e_cnd(e_cnd),
    .m_busy(m_busy), .w_icode(w_icode),
    .f_stall(f_stall), .d_stall(d_stall), .e_stall(e_stall), .m_stall(m_stall),
    .d_bubble(d_bubble), .e_bubble(e_bubble), .w_bubble(w_bubble),
    .halted(halted), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_ctrl #(.CNT_W(3)) dut_small (
    .clk(clk), .rst(rst),
    .d_icode(d_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .e_icode(e_icode), .e_dstM(e_dstM), .e_cnd(e_cnd),
    .m_busy(m_busy), .w_icode(w_icode),
    .f_stall(s_f_stall), .d_stall(s_d_stall), .e_stall(s_e_stall),
    .m_stall(s_m_stall), .d_bubble(s_d_bubble), .e_bubble(s_e_bubble),
    .w_bubble(s_w_bubble), .halted(s_halted),
    .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
  );

  wire [7:0] ctl = {f_stall, d_stall, e_stall, m_stall,
                    d_bubble, e_bubble, w_bubble, halted};

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic set_idle();
    d_icode = NOP; d_srcA = RNONE; d_srcB = RNONE;
    e_icode = NOP; e_dstM = RNONE; e_cnd = 1'b0;
    m_busy = 1'b0; w_icode = NOP;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag, input logic [31:0] st,
                           input logic [31:0] bu);
    check({tag, ".stall_cnt"}, stall_cnt, st);
    check({tag, ".bubble_cnt"}, bubble_cnt, bu);
  endtask

  initial begin
    // Reset with every input at 0 (note w_icode=0 is HALT, masked by reset)
    d_icode = '0; d_srcA = '0; d_srcB = '0; e_icode = '0; e_dstM = '0;
    e_cnd = 1'b0; m_busy = 1'b0; w_icode = '0;
    #2 rst = 1'b0;
    #1;
    check("reset.ctl", {24'd0, ctl}, {24'd0, C_IDLE});
    check_cnt("reset", 32'd0, 32'd0);
    check("reset.small_stall", {29'd0, s_stall_cnt}, 32'd0);
    set_idle();
    #1 rst = 1'b1;

    // Idle for 10 cycles
    repeat (10) next_cycle();
    @(negedge clk);
    check("idle.ctl", {24'd0, ctl}, {24'd0, C_IDLE});
    check_cnt("idle", 32'd0, 32'd0);

    // Load-use via srcA (mrmovl)
    next_cycle();
    e_icode = MRMOVL; e_dstM = 8'd3; d_srcA = 8'd3;
    @(negedge clk);
    check("lu_a.ctl", {24'd0, ctl}, {24'd0, C_LU});
    next_cycle();
    set_idle();
    @(negedge clk);
    check("lu_a.after", {24'd0, ctl}, {24'd0, C_IDLE});
    check_cnt("lu_a", 32'd1, 32'd1);

    // Load-use via srcB (popl)
    next_cycle();
    e_icode = POPL; e_dstM = 8'd5; d_srcB = 8'd5;
    @(negedge clk);
    check("lu_b.ctl", {24'd0, ctl}, {24'd0, C_LU});
    next_cycle();
    // RNONE destination never matches, even against RNONE sources
    e_icode = MRMOVL; e_dstM = RNONE; d_srcA = RNONE; d_srcB = RNONE;
    @(negedge clk);
    check("lu_rnone.ctl", {24'd0, ctl}, {24'd0, C_IDLE});
    check_cnt("lu_b", 32'd2, 32'd2);
    next_cycle();
    set_idle();

    // ret: three bubble cycles; d_icode is ignored inside the window
    d_icode = RET;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("ret.c%0d", i), {24'd0, ctl}, {24'd0, C_RET});
      next_cycle();
    end
    d_icode = NOP;
    @(negedge clk);
    check("ret.end", {24'd0, ctl}, {24'd0, C_IDLE});
    check_cnt("ret", 32'd5, 32'd5);
    next_cycle();

    // ret with a 2-cycle memory freeze inside the window
    begin
      logic [7:0] exp_seq [5];
      exp_seq = '{C_RET, C_FREEZE, C_FREEZE, C_RET, C_RET};
      for (int i = 0; i < 5; i++) begin
        d_icode = (i == 0) ? RET : NOP;
        m_busy  = (i == 1 || i == 2);
        @(negedge clk);
        check($sformatf("retbusy.c%0d", i), {24'd0, ctl}, {24'd0, exp_seq[i]});
        next_cycle();
      end
    end
    set_idle();
    @(negedge clk);
    check("retbusy.end", {24'd0, ctl}, {24'd0, C_IDLE});
    check_cnt("retbusy", 32'd10, 32'd8);
    next_cycle();

    // Mispredict wins over ret in decode
    e_icode = JXX; e_cnd = 1'b0; d_icode = RET;
    @(negedge clk);
    check("misp.ctl", {24'd0, ctl}, {24'd0, C_MISP});
    next_cycle();
    set_idle();
    @(negedge clk);
    check("misp.after", {24'd0, ctl}, {24'd0, C_IDLE});
    check_cnt("misp", 32'd10, 32'd9);
    next_cycle();

    // Mispredict cancels an active ret window
    d_icode = RET;
    @(negedge clk);
    check("cancel.ret", {24'd0, ctl}, {24'd0, C_RET});
    next_cycle();
    d_icode = NOP; e_icode = JXX; e_cnd = 1'b0;
    @(negedge clk);
    check("cancel.misp", {24'd0, ctl}, {24'd0, C_MISP});
    next_cycle();
    e_cnd = 1'b1;  // taken jump: prediction correct, no action
    @(negedge clk);
    check("cancel.after", {24'd0, ctl}, {24'd0, C_IDLE});
    check_cnt("cancel", 32'd11, 32'd11);
    next_cycle();
    set_idle();

    // Halt deferred by memory freeze, then sticky
    w_icode = HALT; m_busy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("halt.busy%0d", i), {24'd0, ctl}, {24'd0, C_FREEZE});
      next_cycle();
    end
    m_busy = 1'b0;
    @(negedge clk);
    check("halt.pre", {24'd0, ctl}, {24'd0, C_IDLE});
    next_cycle();
    set_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("halt.h%0d", i), {24'd0, ctl}, {24'd0, C_HALT});
      next_cycle();
    end
    check_cnt("halt", 32'd13, 32'd11);

    // Asynchronous reset out of HALTED, mid-cycle
    rst = 1'b0;
    #1;
    check("rst_halt.ctl", {24'd0, ctl}, {24'd0, C_IDLE});
    check_cnt("rst_halt", 32'd0, 32'd0);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_halt.run", {24'd0, ctl}, {24'd0, C_IDLE});
    next_cycle();

    // Saturation on the 3-bit instance: 9 load-use cycles
    e_icode = MRMOVL; e_dstM = 8'd2; d_srcB = 8'd2;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check($sformatf("sat.c%0d.ctl", i), {24'd0, ctl}, {24'd0, C_LU});
      check($sformatf("sat.c%0d.small_stall", i), {29'd0, s_stall_cnt},
            (i > 7) ? 32'd7 : i);
      next_cycle();
    end
    set_idle();
    @(negedge clk);
    check("sat.small_stall", {29'd0, s_stall_cnt}, 32'd7);
    check("sat.small_bubble", {29'd0, s_bubble_cnt}, 32'd7);
    check_cnt("sat.main", 32'd9, 32'd9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
